// File: rtl/tetris_input_scheduler_if.sv
// tetris_input_scheduler_if: command handshake between the button scheduler and the piece-movement logic.
interface tetris_input_scheduler_if;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;
    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/tetris_input_scheduler.sv
// tetris_input_scheduler: edge-detects four buttons, keeps sticky requests, arbitrates them onto one
// command port and adds delayed auto-shift repeat for a single held left/right direction.
module tetris_input_scheduler #(
    parameter int DAS_DELAY  = 16,
    parameter int ARR_PERIOD = 4,
    parameter int CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic [3:0]                     btn,
    output logic                           repeat_on,
    tetris_input_scheduler_if.master       cmd
);
    typedef enum logic { A_IDLE, A_OFFER } arb_t;
    typedef enum logic [1:0] { D_NONE, D_WAIT, D_REP } das_t;

    localparam logic [CNT_W-1:0] DAS_C = CNT_W'(DAS_DELAY);
    localparam logic [CNT_W-1:0] ARR_C = CNT_W'(ARR_PERIOD);

    arb_t             arb_q, arb_d;
    das_t             das_q, das_d;
    logic [3:0]       btn_prev_q, pending_q, pending_d, rise;
    logic             dir_q, dir_d, repeat_on_q, repeat_on_d, cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_code_q, cmd_code_d, fire, held_lr, rise_lr;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             xfer, drop_xfer;

    always_comb begin
        rise      = btn & ~btn_prev_q;
        held_lr   = btn[1:0];
        rise_lr   = rise[1:0];
        xfer      = cmd_valid_q & cmd.cmd_ready;
        drop_xfer = xfer & (cmd_code_q == 2'b11);
        cnt_inc   = cnt_q + 1'b1;
        das_d       = das_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        repeat_on_d = repeat_on_q;
        fire        = 2'b00;
        if (das_q == D_NONE) begin
            if ((held_lr[0] ^ held_lr[1]) && !drop_xfer) begin
                das_d = D_WAIT;
                dir_d = held_lr[1];
                cnt_d = '0;
            end
        end else if (!held_lr[dir_q] || &held_lr || rise_lr[!dir_q] || drop_xfer) begin
            das_d       = D_NONE;
            cnt_d       = '0;
            repeat_on_d = 1'b0;
        end else if (rise_lr[dir_q]) begin
            cnt_d = '0;
        end else if (tick) begin
            // The tick that reaches the threshold fires; counter never passes the target.
            if (cnt_inc == ((das_q == D_WAIT) ? DAS_C : ARR_C)) begin
                fire[dir_q] = 1'b1;
                cnt_d       = '0;
                repeat_on_d = 1'b1;
                das_d       = D_REP;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        pending_d = pending_q;
        if (drop_xfer)
            pending_d = '0;
        else if (xfer)
            pending_d[cmd_code_q] = 1'b0;
        pending_d = pending_d | rise | {2'b00, fire};
        arb_d       = arb_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        if (arb_q == A_IDLE) begin
            if (|pending_q) begin
                arb_d       = A_OFFER;
                cmd_valid_d = 1'b1;
                cmd_code_d  = pending_q[3] ? 2'b11 : pending_q[2] ? 2'b10 : pending_q[0] ? 2'b00 : 2'b01;
            end
        end else if (cmd.cmd_ready) begin
            arb_d       = A_IDLE;
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_q       <= A_IDLE;
            das_q       <= D_NONE;
            btn_prev_q  <= '0;
            pending_q   <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            repeat_on_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 2'b00;
        end else begin
            arb_q       <= arb_d;
            das_q       <= das_d;
            btn_prev_q  <= btn;
            pending_q   <= pending_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            repeat_on_q <= repeat_on_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_code  = cmd_code_q;
    assign repeat_on     = repeat_on_q;
endmodule

// File: tb/tb_tetris_input_scheduler.sv
// tb_tetris_input_scheduler: directed stimulus with a code scoreboard checked by an independent monitor.
module tb_tetris_input_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       repeat_on;
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    logic [1:0] exp_q[$];
    logic       hold_f = 1'b0;
    logic [1:0] hold_code = 2'b00;

    tetris_input_scheduler_if bus();

    tetris_input_scheduler #(.DAS_DELAY(3), .ARR_PERIOD(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn(btn), .repeat_on(repeat_on), .cmd(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake and checks offers stay stable while stalled.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            hold_f = 1'b0;
        end else begin
            if (hold_f) begin
                chk("hold_valid", bus.cmd_valid, 1);
                chk("hold_code", bus.cmd_code, hold_code);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_q.size() == 0) chk("sb_extra_cmd", 1, 0);
                else chk("sb_code", bus.cmd_code, exp_q.pop_front());
            end
            hold_f    = bus.cmd_valid && !bus.cmd_ready;
            hold_code = bus.cmd_code;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.cmd_ready = 1'b0;
        cyc(2);
        chk("rst_valid", bus.cmd_valid, 0);
        chk("rst_code", bus.cmd_code, 0);
        chk("rst_repeat", repeat_on, 0);
        // T1: asynchronous reset during an offer, then release with rotate held
        reset = 1'b1;
        btn = 4'b0100;
        cyc(2);
        chk("t1_offer", bus.cmd_valid, 1);
        #3 reset = 1'b0;
        #1;
        chk("t1_async_valid", bus.cmd_valid, 0);
        chk("t1_async_code", bus.cmd_code, 0);
        cyc(2);
        exp_q.push_back(2'b10);
        bus.cmd_ready = 1'b1;
        reset = 1'b1;
        cyc(10);
        chk("t1_drain", exp_q.size(), 0);
        btn = 4'b0000;
        cyc(3);
        // T2: single press latency and no repeat on a held rotate
        exp_q.push_back(2'b10);
        btn = 4'b0100;
        cyc(1);
        chk("t2_lat0", bus.cmd_valid, 0);
        cyc(1);
        chk("t2_valid", bus.cmd_valid, 1);
        chk("t2_code", bus.cmd_code, 2);
        cyc(1);
        chk("t2_idle", bus.cmd_valid, 0);
        cyc(20);
        chk("t2_drain", exp_q.size(), 0);
        btn = 4'b0000;
        cyc(3);
        // T3: drop beats left, held while stalled, and wipes the left request
        bus.cmd_ready = 1'b0;
        exp_q.push_back(2'b11);
        btn = 4'b1001;
        cyc(2);
        chk("t3_valid", bus.cmd_valid, 1);
        chk("t3_code", bus.cmd_code, 3);
        cyc(3);
        chk("t3_code_held", bus.cmd_code, 3);
        bus.cmd_ready = 1'b1;
        cyc(8);
        chk("t3_drain", exp_q.size(), 0);
        chk("t3_repeat", repeat_on, 0);
        btn = 4'b0000;
        cyc(3);
        // T4: rotate before left with exactly one idle cycle between
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        btn = 4'b0101;
        cyc(2);
        chk("t4_first_valid", bus.cmd_valid, 1);
        chk("t4_first_code", bus.cmd_code, 2);
        cyc(1);
        chk("t4_idle", bus.cmd_valid, 0);
        cyc(1);
        chk("t4_second_valid", bus.cmd_valid, 1);
        chk("t4_second_code", bus.cmd_code, 0);
        cyc(4);
        chk("t4_drain", exp_q.size(), 0);
        btn = 4'b0000;
        cyc(3);
        // T5: held left, repeats fire on ticks 3, 5, 7, 9
        exp_q.push_back(2'b00);
        btn = 4'b0001;
        for (int n = 1; n <= 10; n++) begin
            cyc(3);
            chk("t5_drain", exp_q.size(), 0);
            chk("t5_repeat", repeat_on, (n >= 4) ? 1 : 0);
            if (n == 3 || n == 5 || n == 7 || n == 9) exp_q.push_back(2'b00);
            pulse_tick();
        end
        cyc(3);
        chk("t5_end_drain", exp_q.size(), 0);
        chk("t5_end_repeat", repeat_on, 1);
        btn = 4'b0000;
        cyc(1);
        chk("t5_release_repeat", repeat_on, 0);
        cyc(10);
        chk("t5_release_drain", exp_q.size(), 0);
        // T6: both directions held cancels auto-shift
        exp_q.push_back(2'b00);
        btn = 4'b0001;
        cyc(3);
        exp_q.push_back(2'b01);
        btn = 4'b0011;
        for (int n = 0; n < 10; n++) begin
            cyc(3);
            pulse_tick();
            chk("t6_repeat", repeat_on, 0);
        end
        chk("t6_drain", exp_q.size(), 0);
        btn = 4'b0000;
        cyc(5);
        chk("t6_final_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
